// File: rtl/pg_seq_ctrl.sv
// pg_seq_ctrl -- timebase sequencer and configuration front end for a bank
// of one-shot pulse channels.
//
// Ports:
//   i_clk, i_res          clock; synchronous active-high reset
//   i_wr_en/addr/data     host config write port (shadow registers)
//   i_start, i_stop       start / abort requests (single-cycle pulses)
//   i_trig                external trigger, already synchronous to i_clk
//   o_cnt                 shared timebase count
//   o_st, o_end           active start/end compare values, CW bits per channel
//   o_run, o_busy         timebase running / sequencer not idle
//   o_period_tick         last count of every period
//   o_done                one-cycle pulse when a burst completes
//
// Register map: 0x0 PERIOD, 0x1 BURST (0 = continuous), 0x2 CTRL[0] TRIG_EN,
// 0x8+2k ST[k], 0x9+2k END[k].

module pg_seq_regs #(
   parameter int CH_NUM = 4,
   parameter int CW     = 24
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 wr_en,
   input  logic [3:0]           wr_addr,
   input  logic [CW-1:0]        wr_data,
   output logic [CW-1:0]        period,
   output logic [CW-1:0]        burst,
   output logic                 trig_en,
   output logic [CH_NUM*CW-1:0] st_val,
   output logic [CH_NUM*CW-1:0] end_val
);

   logic [CW-1:0] st_mem  [CH_NUM];
   logic [CW-1:0] end_mem [CH_NUM];

   always_ff @(posedge clk) begin
      if (res) begin
         period  <= CW'(1000);
         burst   <= '0;
         trig_en <= 1'b0;
         for (int k = 0; k < CH_NUM; k++) begin
            st_mem[k]  <= '0;
            end_mem[k] <= '0;
         end
      end else if (wr_en) begin
         case (wr_addr)
            4'h0:    period  <= wr_data;
            4'h1:    burst   <= wr_data;
            4'h2:    trig_en <= wr_data[0];
            default: ;
         endcase
         for (int k = 0; k < CH_NUM; k++) begin
            if (wr_addr == 4'(8 + 2 * k)) st_mem[k]  <= wr_data;
            if (wr_addr == 4'(9 + 2 * k)) end_mem[k] <= wr_data;
         end
      end
   end

   for (genvar k = 0; k < CH_NUM; k++) begin : g_flat
      assign st_val[k*CW +: CW]  = st_mem[k];
      assign end_val[k*CW +: CW] = end_mem[k];
   end

endmodule

// state | meaning
// IDLE  | stopped; o_cnt held at 0, active compare values held
// ARMED | started with TRIG_EN, waiting for i_trig
// RUN   | timebase counting 0..PERIOD-1, channels enabled
module pg_seq_ctrl #(
   parameter int CH_NUM = 4,
   parameter int CW     = 24
) (
   input  logic                 i_clk,
   input  logic                 i_res,
   input  logic                 i_wr_en,
   input  logic [3:0]           i_wr_addr,
   input  logic [CW-1:0]        i_wr_data,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_trig,
   output logic [CW-1:0]        o_cnt,
   output logic [CH_NUM*CW-1:0] o_st,
   output logic [CH_NUM*CW-1:0] o_end,
   output logic                 o_run,
   output logic                 o_busy,
   output logic                 o_period_tick,
   output logic                 o_done
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        period_sh, burst_sh, period_act, burst_rem;
   logic                 trig_en_sh;
   logic [CH_NUM*CW-1:0] st_sh, end_sh;
   logic                 arm, load, tc, done_nxt;

   pg_seq_regs #(.CH_NUM(CH_NUM), .CW(CW)) u_regs (
      .clk     (i_clk),
      .res     (i_res),
      .wr_en   (i_wr_en),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .period  (period_sh),
      .burst   (burst_sh),
      .trig_en (trig_en_sh),
      .st_val  (st_sh),
      .end_val (end_sh)
   );

   // period_act is never below 2 while running, so PERIOD-1 cannot underflow
   assign tc            = (state == RUN) && (o_cnt == period_act - CW'(1));
   assign o_run         = (state == RUN);
   assign o_busy        = (state != IDLE);
   assign o_period_tick = tc;

   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      load      = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_start && !i_stop) begin
               arm = 1'b1;
               if (trig_en_sh) begin
                  state_nxt = ARMED;
               end else begin
                  state_nxt = RUN;
                  load      = 1'b1;
               end
            end
         end
         ARMED: begin
            if (i_stop) begin
               state_nxt = IDLE;
            end else if (i_trig) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (i_stop) begin
               state_nxt = IDLE;
            end else if (tc) begin
               // burst_rem == 0 means continuous; it never reaches 1 then
               if (burst_rem == CW'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         state      <= IDLE;
         o_cnt      <= '0;
         o_done     <= 1'b0;
         period_act <= '0;
         burst_rem  <= '0;
         o_st       <= '0;
         o_end      <= '0;
      end else begin
         state  <= state_nxt;
         o_done <= done_nxt;
         if (state == RUN && state_nxt == RUN && !tc) o_cnt <= o_cnt + CW'(1);
         else                                         o_cnt <= '0;
         // remaining-periods down-counter; terminal count 1 ends the burst
         if (arm)                                        burst_rem <= burst_sh;
         else if (tc && !i_stop && burst_rem != '0)      burst_rem <= burst_rem - CW'(1);
         // shadow values are read before any same-cycle write lands
         if (load) begin
            period_act <= (period_sh < CW'(2)) ? CW'(2) : period_sh;
            o_st       <= st_sh;
            o_end      <= end_sh;
         end
      end
   end

endmodule
